time_counter: RTL and testbench
===============================

Name: time_counter

Overview:
- Consumer end of the timegen strobe interface. Takes the one_second and one_minute pulses from timegen and maintains the displayed wall-clock time as four BCD digits, HH:MM in 24-hour format.
- Also supports a validated time load, a blinking colon driven by one_second, and a day-rollover pulse.
- Sits between timegen and the display/alarm-compare logic of the clock design.

Parameters:
- RESET_HH, 8'h00, BCD hours {tens,ones} loaded on reset; must be a legal value 00-23.
- RESET_MM, 8'h00, BCD minutes {tens,ones} loaded on reset; must be a legal value 00-59.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- one_second  input  1  strobe from timegen.
- one_minute  input  1  strobe from timegen; in stopwatch mode it arrives every second, with no special handling here.
- load_time  input  1  request to load new_time.
- new_time  input  16  BCD {hour_t, hour_o, min_t, min_o}, 4 bits each.
- hour_tens  output  4  BCD, range 0-2.
- hour_ones  output  4  BCD, range 0-9.
- min_tens  output  4  BCD, range 0-5.
- min_ones  output  4  BCD, range 0-9.
- colon  output  1  display colon; toggles once per second.
- day_rollover  output  1  one-cycle pulse on 23:59 -> 00:00.
- load_err  output  1  one-cycle pulse when a load is rejected.

Behaviour:
- Reset values: digits = RESET_HH/RESET_MM; colon = 0; day_rollover = 0; load_err = 0; strobe history registers = 0.
- Strobe detection:
  - one_second and one_minute are rising-edge detected against a registered copy.
  - A strobe held high for N cycles counts once.
  - A strobe high in the first cycle after reset counts as a rising edge.
- Latency: an event sampled at edge k is visible on the outputs after edge k. All outputs are registered.
- Priority: reset > load_time > minute increment.
- Load:
  - Legal when every nibble is ≤ 9, min_t ≤ 5, and hours ≤ 23 (hour_t ≤ 2; hour_o ≤ 3 if hour_t = 2).
  - Legal load: digits take new_time; colon forced to 1; the minute edge in that same cycle is dropped.
  - Illegal load: digits unchanged; load_err = 1 for exactly one cycle; the minute edge in that cycle is applied normally.
  - load_time is level-sampled, so holding it re-loads every cycle.
- Minute increment, ripple carry within one cycle:
  - min_ones 9 -> 0 carries into min_tens.
  - min_tens 5 -> 0 carries into hours.
  - hour_ones 9 -> 0 carries into hour_tens.
  - At 23 with an hour carry, hours go to 00 and day_rollover = 1 for one cycle.
- Colon:
  - Toggles on each one_second rising edge, independent of load and minute events.
  - When a legal load coincides with a second edge, the forced 1 wins.
- Reset mid-operation: all state returns to reset values on that edge; pending pulses are cleared.
- Pulse outputs are 0 in every cycle without their triggering event.

Decomposition:
- Package time_pkg:
  - BCD digit width (4).
  - Digit limits: MIN_ONES_MAX = 9, MIN_TENS_MAX = 5, HOUR_TENS_MAX = 2, HOUR_ONES_MAX_AT_2 = 3.
  - Function bcd_time_valid(16-bit) used by both RTL and bench.
- Sub-module bcd_digit:
  - Modulo-(MAX+1) counter with inputs inc, load, load_val, wrap_max (runtime, for the hour_ones 3/9 case) and reset value.
  - Output carry_out, asserted when inc is applied and the digit wraps.
  - Instantiated four times; top level holds edge detectors, load validation, colon and pulse logic.

Test Plan:
- Reset with defaults, then 10 one_minute pulses (1 cycle each, 20 cycles apart) -> 00:10, colon 0, no rollover.
- Legal load 16'h2359, then one one_minute edge -> 00:00 after the edge, day_rollover high exactly one cycle; load 16'h0959 + minute -> 10:00.
- Illegal loads 16'h2400, 16'h1260, 16'h0A00 -> digits unchanged, load_err one-cycle pulse each; a coincident minute edge still increments.
- one_minute held high 5 cycles -> single increment; load_time with coincident one_minute on load of 16'h1200 -> 12:00, not 12:01.
- one_second edges: 3 edges -> colon 1,0,1; legal load coincident with a second edge -> colon 1.
- Reset asserted mid-count at 14:37 with colon 1 -> next cycle 00:00 (or the RESET_HH/RESET_MM values), colon 0, pulses 0.

Source files
------------

// File: rtl/time_pkg.sv
// Shared definitions for the wall-clock time counter: BCD digit width,
// per-digit limits and the legality check for a 24-hour HH:MM value.
package time_pkg;

  // Width of one BCD digit.
  localparam int BCD_W = 4;

  // Largest value each digit may hold.
  localparam logic [BCD_W-1:0] MIN_ONES_MAX       = 4'd9;
  localparam logic [BCD_W-1:0] MIN_TENS_MAX       = 4'd5;
  localparam logic [BCD_W-1:0] HOUR_ONES_MAX      = 4'd9;
  localparam logic [BCD_W-1:0] HOUR_TENS_MAX      = 4'd2;
  localparam logic [BCD_W-1:0] HOUR_ONES_MAX_AT_2 = 4'd3;

  // Returns 1 when {hour_t, hour_o, min_t, min_o} is a legal 24-hour time
  // (00:00 .. 23:59) with every nibble a valid BCD digit.
  function automatic logic bcd_time_valid(input logic [15:0] t);
    logic [BCD_W-1:0] v_ht;
    logic [BCD_W-1:0] v_ho;
    logic [BCD_W-1:0] v_mt;
    logic [BCD_W-1:0] v_mo;
    logic             v_ok;
    v_ht = t[15:12];
    v_ho = t[11:8];
    v_mt = t[7:4];
    v_mo = t[3:0];
    v_ok = 1'b1;
    if (v_mo > MIN_ONES_MAX) begin
      v_ok = 1'b0;
    end else begin
      v_ok = v_ok;
    end
    if (v_mt > MIN_TENS_MAX) begin
      v_ok = 1'b0;
    end else begin
      v_ok = v_ok;
    end
    if (v_ho > HOUR_ONES_MAX) begin
      v_ok = 1'b0;
    end else begin
      v_ok = v_ok;
    end
    if (v_ht > HOUR_TENS_MAX) begin
      v_ok = 1'b0;
    end else if ((v_ht == HOUR_TENS_MAX) && (v_ho > HOUR_ONES_MAX_AT_2)) begin
      v_ok = 1'b0;
    end else begin
      v_ok = v_ok;
    end
    return v_ok;
  endfunction

endpackage

// File: rtl/time_counter_bcd_digit.sv
// One BCD digit of the time display: a modulo-(wrap_max+1) counter with a
// synchronous load. The wrap point is a runtime input so the hour-ones digit
// can wrap at 3 when the hour-tens digit is 2 and at 9 otherwise.
module bcd_digit
  import time_pkg::*;
#(
  parameter logic [BCD_W-1:0] RESET_VAL = 4'd0
) (
  input  logic             clk,
  input  logic             i_reset,
  input  logic             i_inc,
  input  logic             i_load,
  input  logic [BCD_W-1:0] i_load_val,
  input  logic [BCD_W-1:0] i_wrap_max,
  output logic [BCD_W-1:0] o_digit,
  output logic             o_carry
);

  logic [BCD_W-1:0] r_digit;
  logic             w_at_wrap;

  // Wrap detection and carry: ">=" also recovers cleanly from any value above
  // the current wrap point. A load takes precedence, so no carry is produced
  // in a load cycle.
  always_comb begin
    w_at_wrap = 1'b0;
    o_carry   = 1'b0;
    if (r_digit >= i_wrap_max) begin
      w_at_wrap = 1'b1;
    end else begin
      w_at_wrap = 1'b0;
    end
    if (i_inc && !i_load && w_at_wrap) begin
      o_carry = 1'b1;
    end else begin
      o_carry = 1'b0;
    end
  end

  // Digit register: reset, then load, then increment with wrap.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_digit <= RESET_VAL;
    end else if (i_load) begin
      r_digit <= i_load_val;
    end else if (i_inc) begin
      if (w_at_wrap) begin
        r_digit <= 4'd0;
      end else begin
        r_digit <= r_digit + 4'd1;
      end
    end else begin
      r_digit <= r_digit;
    end
  end

  assign o_digit = r_digit;

endmodule

// File: rtl/time_counter.sv
// Wall-clock HH:MM counter fed by the timegen one_second/one_minute strobes.
// Holds strobe edge detectors, load validation, the blinking colon and the
// day-rollover / load-error pulses; the four digits live in bcd_digit.
// RESET_HH and RESET_MM must be legal BCD times (00-23, 00-59).
module time_counter
  import time_pkg::*;
#(
  parameter logic [7:0] RESET_HH = 8'h00,
  parameter logic [7:0] RESET_MM = 8'h00
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             one_second,
  input  logic             one_minute,
  input  logic             load_time,
  input  logic [15:0]      new_time,
  output logic [BCD_W-1:0] hour_tens,
  output logic [BCD_W-1:0] hour_ones,
  output logic [BCD_W-1:0] min_tens,
  output logic [BCD_W-1:0] min_ones,
  output logic             colon,
  output logic             day_rollover,
  output logic             load_err
);

  // Strobe history and registered flag outputs.
  logic r_sec_prev;
  logic r_min_prev;
  logic r_colon;
  logic r_day_rollover;
  logic r_load_err;

  // Decoded events for the current cycle.
  logic w_sec_edge;
  logic w_min_edge;
  logic w_new_valid;
  logic w_load_ok;
  logic w_load_bad;
  logic w_inc;

  // Ripple-carry chain between digits.
  logic w_mo_carry;
  logic w_mt_carry;
  logic w_ho_carry;
  logic w_ht_carry;
  logic [BCD_W-1:0] w_ho_wrap;

  // Edge detection, load classification and minute gating. A legal load
  // drops a coincident minute edge; a rejected load lets it through.
  always_comb begin
    w_sec_edge  = 1'b0;
    w_min_edge  = 1'b0;
    w_new_valid = 1'b0;
    w_load_ok   = 1'b0;
    w_load_bad  = 1'b0;
    w_inc       = 1'b0;
    w_sec_edge  = one_second & ~r_sec_prev;
    w_min_edge  = one_minute & ~r_min_prev;
    w_new_valid = bcd_time_valid(new_time);
    if (load_time) begin
      if (w_new_valid) begin
        w_load_ok  = 1'b1;
        w_load_bad = 1'b0;
      end else begin
        w_load_ok  = 1'b0;
        w_load_bad = 1'b1;
      end
    end else begin
      w_load_ok  = 1'b0;
      w_load_bad = 1'b0;
    end
    w_inc = w_min_edge & ~w_load_ok;
  end

  // Hour-ones wraps at 3 only while the hour-tens digit reads 2.
  always_comb begin
    w_ho_wrap = HOUR_ONES_MAX;
    if (hour_tens == HOUR_TENS_MAX) begin
      w_ho_wrap = HOUR_ONES_MAX_AT_2;
    end else begin
      w_ho_wrap = HOUR_ONES_MAX;
    end
  end

  bcd_digit #(
    .RESET_VAL (RESET_MM[3:0])
  ) u_min_ones (
    .clk        (clk),
    .i_reset    (reset),
    .i_inc      (w_inc),
    .i_load     (w_load_ok),
    .i_load_val (new_time[3:0]),
    .i_wrap_max (MIN_ONES_MAX),
    .o_digit    (min_ones),
    .o_carry    (w_mo_carry)
  );

  bcd_digit #(
    .RESET_VAL (RESET_MM[7:4])
  ) u_min_tens (
    .clk        (clk),
    .i_reset    (reset),
    .i_inc      (w_mo_carry),
    .i_load     (w_load_ok),
    .i_load_val (new_time[7:4]),
    .i_wrap_max (MIN_TENS_MAX),
    .o_digit    (min_tens),
    .o_carry    (w_mt_carry)
  );

  bcd_digit #(
    .RESET_VAL (RESET_HH[3:0])
  ) u_hour_ones (
    .clk        (clk),
    .i_reset    (reset),
    .i_inc      (w_mt_carry),
    .i_load     (w_load_ok),
    .i_load_val (new_time[11:8]),
    .i_wrap_max (w_ho_wrap),
    .o_digit    (hour_ones),
    .o_carry    (w_ho_carry)
  );

  bcd_digit #(
    .RESET_VAL (RESET_HH[7:4])
  ) u_hour_tens (
    .clk        (clk),
    .i_reset    (reset),
    .i_inc      (w_ho_carry),
    .i_load     (w_load_ok),
    .i_load_val (new_time[15:12]),
    .i_wrap_max (HOUR_TENS_MAX),
    .o_digit    (hour_tens),
    .o_carry    (w_ht_carry)
  );

  // Strobe history: cleared on reset so a strobe already high in the first
  // cycle after reset is seen as a rising edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sec_prev <= 1'b0;
      r_min_prev <= 1'b0;
    end else begin
      r_sec_prev <= one_second;
      r_min_prev <= one_minute;
    end
  end

  // Colon: a legal load forces it on, overriding a coincident second toggle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_colon <= 1'b0;
    end else if (w_load_ok) begin
      r_colon <= 1'b1;
    end else if (w_sec_edge) begin
      r_colon <= ~r_colon;
    end else begin
      r_colon <= r_colon;
    end
  end

  // One-cycle pulses: the carry out of hour-tens is exactly the 23:59 -> 00:00
  // wrap, and a rejected load flags an error.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_day_rollover <= 1'b0;
      r_load_err     <= 1'b0;
    end else begin
      r_day_rollover <= w_ht_carry;
      r_load_err     <= w_load_bad;
    end
  end

  assign colon        = r_colon;
  assign day_rollover = r_day_rollover;
  assign load_err     = r_load_err;

endmodule

// File: tb/tb_time_counter.sv
// Directed bench for time_counter: linear stimulus with hand-computed
// expected times and pulse values, checked by immediate assertions.
module tb_time_counter;
  import time_pkg::*;

  logic        clk;
  logic        reset;
  logic        one_second;
  logic        one_minute;
  logic        load_time;
  logic [15:0] new_time;
  logic [3:0]  hour_tens;
  logic [3:0]  hour_ones;
  logic [3:0]  min_tens;
  logic [3:0]  min_ones;
  logic        colon;
  logic        day_rollover;
  logic        load_err;

  int n_assert;
  int n_fail;

  time_counter #(
    .RESET_HH (8'h00),
    .RESET_MM (8'h00)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .one_second   (one_second),
    .one_minute   (one_minute),
    .load_time    (load_time),
    .new_time     (new_time),
    .hour_tens    (hour_tens),
    .hour_ones    (hour_ones),
    .min_tens     (min_tens),
    .min_ones     (min_ones),
    .colon        (colon),
    .day_rollover (day_rollover),
    .load_err     (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] now_time();
    return {hour_tens, hour_ones, min_tens, min_ones};
  endfunction

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_assert   = 0;
    n_fail     = 0;
    reset      = 1'b1;
    one_second = 1'b0;
    one_minute = 1'b0;
    load_time  = 1'b0;
    new_time   = 16'h0000;

    // Package legality helper on hand-picked values.
    check("valid_2359", 32'(bcd_time_valid(16'h2359)), 32'd1);
    check("valid_1959", 32'(bcd_time_valid(16'h1959)), 32'd1);
    check("valid_2400", 32'(bcd_time_valid(16'h2400)), 32'd0);
    check("valid_1260", 32'(bcd_time_valid(16'h1260)), 32'd0);
    check("valid_0A00", 32'(bcd_time_valid(16'h0A00)), 32'd0);
    check("valid_3000", 32'(bcd_time_valid(16'h3000)), 32'd0);

    // Reset state.
    tick();
    tick();
    reset = 1'b0;
    check("rst_time", 32'(now_time()), 32'h0000);
    check("rst_colon", 32'(colon), 32'd0);
    check("rst_roll", 32'(day_rollover), 32'd0);
    check("rst_err", 32'(load_err), 32'd0);

    // Ten single-cycle minute strobes, 20 cycles apart.
    for (int i = 0; i < 10; i++) begin
      one_minute = 1'b1;
      tick();
      one_minute = 1'b0;
      repeat (19) tick();
    end
    check("ten_min_time", 32'(now_time()), 32'h0010);
    check("ten_min_colon", 32'(colon), 32'd0);
    check("ten_min_roll", 32'(day_rollover), 32'd0);

    // Legal load 23:59 then a minute: day rollover.
    load_time = 1'b1;
    new_time  = 16'h2359;
    tick();
    load_time = 1'b0;
    check("load_2359", 32'(now_time()), 32'h2359);
    check("load_2359_colon", 32'(colon), 32'd1);
    check("load_2359_err", 32'(load_err), 32'd0);
    one_minute = 1'b1;
    tick();
    one_minute = 1'b0;
    check("roll_time", 32'(now_time()), 32'h0000);
    check("roll_pulse", 32'(day_rollover), 32'd1);
    tick();
    check("roll_pulse_end", 32'(day_rollover), 32'd0);

    // 09:59 + minute -> 10:00.
    load_time = 1'b1;
    new_time  = 16'h0959;
    tick();
    load_time  = 1'b0;
    one_minute = 1'b1;
    tick();
    one_minute = 1'b0;
    check("carry_1000", 32'(now_time()), 32'h1000);
    check("carry_1000_roll", 32'(day_rollover), 32'd0);

    // 19:59 + minute -> 20:00.
    load_time = 1'b1;
    new_time  = 16'h1959;
    tick();
    load_time  = 1'b0;
    one_minute = 1'b1;
    tick();
    one_minute = 1'b0;
    check("carry_2000", 32'(now_time()), 32'h2000);

    // Back to 10:00 for the illegal-load checks.
    load_time = 1'b1;
    new_time  = 16'h1000;
    tick();
    load_time = 1'b0;

    // Illegal 24:00, no minute: digits held, one error pulse.
    load_time = 1'b1;
    new_time  = 16'h2400;
    tick();
    load_time = 1'b0;
    check("bad_2400_time", 32'(now_time()), 32'h1000);
    check("bad_2400_err", 32'(load_err), 32'd1);
    tick();
    check("bad_2400_err_end", 32'(load_err), 32'd0);

    // Illegal 12:60 with a coincident minute: minute still applies.
    load_time  = 1'b1;
    one_minute = 1'b1;
    new_time   = 16'h1260;
    tick();
    load_time  = 1'b0;
    one_minute = 1'b0;
    check("bad_1260_time", 32'(now_time()), 32'h1001);
    check("bad_1260_err", 32'(load_err), 32'd1);
    tick();
    check("bad_1260_err_end", 32'(load_err), 32'd0);

    // Illegal 0A:00 with a coincident minute.
    load_time  = 1'b1;
    one_minute = 1'b1;
    new_time   = 16'h0A00;
    tick();
    load_time  = 1'b0;
    one_minute = 1'b0;
    check("bad_0A00_time", 32'(now_time()), 32'h1002);
    check("bad_0A00_err", 32'(load_err), 32'd1);
    tick();
    check("bad_0A00_err_end", 32'(load_err), 32'd0);

    // Minute strobe held for 5 cycles counts once.
    one_minute = 1'b1;
    repeat (5) tick();
    one_minute = 1'b0;
    check("held_min", 32'(now_time()), 32'h1003);
    tick();
    check("held_min_after", 32'(now_time()), 32'h1003);

    // Legal load 12:00 with coincident minute: minute dropped.
    load_time  = 1'b1;
    one_minute = 1'b1;
    new_time   = 16'h1200;
    tick();
    load_time  = 1'b0;
    one_minute = 1'b0;
    check("load_drop_min", 32'(now_time()), 32'h1200);
    tick();
    check("load_drop_min_after", 32'(now_time()), 32'h1200);

    // Colon is 1 after the load; one edge takes it to 0, then 1,0,1.
    one_second = 1'b1;
    tick();
    one_second = 1'b0;
    check("colon_pre", 32'(colon), 32'd0);
    tick();
    one_second = 1'b1;
    tick();
    one_second = 1'b0;
    check("colon_e1", 32'(colon), 32'd1);
    tick();
    one_second = 1'b1;
    tick();
    one_second = 1'b0;
    check("colon_e2", 32'(colon), 32'd0);
    tick();
    one_second = 1'b1;
    tick();
    one_second = 1'b0;
    check("colon_e3", 32'(colon), 32'd1);
    tick();

    // Legal load with a coincident second edge: forced 1 beats the toggle.
    load_time  = 1'b1;
    one_second = 1'b1;
    new_time   = 16'h1437;
    tick();
    load_time  = 1'b0;
    one_second = 1'b0;
    check("load_sec_time", 32'(now_time()), 32'h1437);
    check("load_sec_colon", 32'(colon), 32'd1);
    tick();

    // Reset mid-operation with a minute and a bad load pending.
    reset      = 1'b1;
    one_minute = 1'b1;
    load_time  = 1'b1;
    new_time   = 16'hFFFF;
    tick();
    load_time = 1'b0;
    check("mid_rst_time", 32'(now_time()), 32'h0000);
    check("mid_rst_colon", 32'(colon), 32'd0);
    check("mid_rst_roll", 32'(day_rollover), 32'd0);
    check("mid_rst_err", 32'(load_err), 32'd0);

    // Minute strobe already high in the first cycle after reset counts.
    reset = 1'b0;
    tick();
    check("post_rst_edge", 32'(now_time()), 32'h0001);
    one_minute = 1'b0;
    tick();
    check("post_rst_hold", 32'(now_time()), 32'h0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
